// File: rtl/estagio_busca.sv
// Instruction-fetch stage: owns the PC, issues variable-latency memory reads and
// holds the fetched word for decode under a valid/ready handshake with flush support.
module estagio_busca #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          INCREMENTO = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] prox_pc,
    input  logic        descarta,
    output logic [31:0] pc,
    output logic [31:0] pc_mais_4,
    output logic        mem_req,
    output logic [31:0] mem_end,
    input  logic        mem_ack,
    input  logic [31:0] mem_dado,
    output logic [31:0] instr,
    output logic [31:0] instr_pc_mais_4,
    output logic        instr_valido,
    input  logic        decod_pronto,
    output logic [31:0] num_instr
);

    typedef enum logic [1:0] {
        BUSCA    = 2'd0,
        ENTREGA  = 2'd1,
        DESCARTE = 2'd2
    } estado_t;

    estado_t estado, prox_estado;
    logic    carrega_pc;
    logic    captura;
    logic    conta;

    assign pc_mais_4    = pc + 32'(INCREMENTO);
    assign mem_end      = {pc[31:2], 2'b00};
    assign mem_req      = (estado == BUSCA);
    assign instr_valido = (estado == ENTREGA);

    always_comb begin
        prox_estado = estado;
        carrega_pc  = 1'b0;
        captura     = 1'b0;
        conta       = 1'b0;
        case (estado)
            BUSCA: begin
                if (descarta) begin
                    carrega_pc = 1'b1;
                    // An ack landing with the flush returns the stale word; drop it here.
                    if (!mem_ack) prox_estado = DESCARTE;
                end else if (mem_ack) begin
                    captura     = 1'b1;
                    prox_estado = ENTREGA;
                end
            end
            ENTREGA: begin
                if (descarta) begin
                    carrega_pc  = 1'b1;
                    prox_estado = BUSCA;
                end else if (decod_pronto) begin
                    carrega_pc  = 1'b1;
                    conta       = 1'b1;
                    prox_estado = BUSCA;
                end
            end
            DESCARTE: begin
                carrega_pc = descarta;
                if (mem_ack) prox_estado = BUSCA;
            end
            default: prox_estado = BUSCA;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= BUSCA;
            pc              <= PC_RESET;
            instr           <= 32'h0;
            instr_pc_mais_4 <= 32'h0;
            num_instr       <= 32'h0;
        end else begin
            estado <= prox_estado;
            if (carrega_pc) pc <= prox_pc;
            if (captura) begin
                instr           <= mem_dado;
                instr_pc_mais_4 <= pc_mais_4;
            end
            if (conta) num_instr <= num_instr + 32'd1;
        end
    end

endmodule
